// File: rtl/chan_ctrl.sv
// Channel control: 512 Hz frame sequencer producing length/sweep/envelope strobes,
// plus the NRx1/NRx3/NRx4 register file and the one-cycle trigger pulse.
module chan_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apu_on,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        len_tick,
    output logic        sweep_tick,
    output logic        env_tick,
    output logic [5:0]  lenLoad,
    output logic        trigger,
    output logic        lenEnable,
    output logic [1:0]  duty,
    output logic [10:0] freq,
    output logic [2:0]  seq_step
);

    localparam logic [12:0] DIV_LAST = 13'd8191;
    localparam logic [2:0]  ADDR_NR1 = 3'd1;
    localparam logic [2:0]  ADDR_NR3 = 3'd3;
    localparam logic [2:0]  ADDR_NR4 = 3'd4;

    // Strobe vector {len, sweep, env} for the step being executed.
    function automatic logic [2:0] strobe_decode(input logic [2:0] step);
        logic [2:0] res;
        case (step)
            3'd0, 3'd4: res = 3'b100;
            3'd2, 3'd6: res = 3'b110;
            3'd7:       res = 3'b001;
            default:    res = 3'b000;
        endcase
        return res;
    endfunction

    logic [12:0] div_r, div_nxt_s;
    logic [2:0]  step_r, step_nxt_s;
    logic [2:0]  strobe_r, strobe_nxt_s;
    logic [1:0]  duty_r, duty_nxt_s;
    logic [5:0]  len_load_r, len_load_nxt_s;
    logic        len_en_r, len_en_nxt_s;
    logic [10:0] freq_r, freq_nxt_s;
    logic        trig_r, trig_nxt_s;

    // Sequencer next state: divider, step counter and the strobe of the step just finished.
    always_comb begin
        div_nxt_s    = div_r;
        step_nxt_s   = step_r;
        strobe_nxt_s = 3'b000;
        if (!apu_on) begin
            div_nxt_s  = 13'd0;
            step_nxt_s = 3'd0;
        end else begin
            div_nxt_s = div_r + 13'd1;
            if (div_r == DIV_LAST) begin
                step_nxt_s   = step_r + 3'd1;
                strobe_nxt_s = strobe_decode(step_r);
            end else begin
                step_nxt_s = step_r;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r    <= 13'd0;
            step_r   <= 3'd0;
            strobe_r <= 3'b000;
        end else begin
            div_r    <= div_nxt_s;
            step_r   <= step_nxt_s;
            strobe_r <= strobe_nxt_s;
        end
    end

    // Register-file next state; the trigger bit of NRx4 only produces a pulse.
    always_comb begin
        duty_nxt_s     = duty_r;
        len_load_nxt_s = len_load_r;
        len_en_nxt_s   = len_en_r;
        freq_nxt_s     = freq_r;
        trig_nxt_s     = 1'b0;
        if (!apu_on) begin
            duty_nxt_s     = 2'd0;
            len_load_nxt_s = 6'd0;
            len_en_nxt_s   = 1'b0;
            freq_nxt_s     = 11'd0;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_NR1: begin
                    duty_nxt_s     = wr_data[7:6];
                    len_load_nxt_s = wr_data[5:0];
                end
                ADDR_NR3: freq_nxt_s[7:0] = wr_data;
                ADDR_NR4: begin
                    freq_nxt_s[10:8] = wr_data[2:0];
                    len_en_nxt_s     = wr_data[6];
                    trig_nxt_s       = wr_data[7];
                end
                default: trig_nxt_s = 1'b0;
            endcase
        end else begin
            trig_nxt_s = 1'b0;
        end
    end

    // Register-file state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r     <= 2'd0;
            len_load_r <= 6'd0;
            len_en_r   <= 1'b0;
            freq_r     <= 11'd0;
            trig_r     <= 1'b0;
        end else begin
            duty_r     <= duty_nxt_s;
            len_load_r <= len_load_nxt_s;
            len_en_r   <= len_en_nxt_s;
            freq_r     <= freq_nxt_s;
            trig_r     <= trig_nxt_s;
        end
    end

    assign len_tick   = strobe_r[2];
    assign sweep_tick = strobe_r[1];
    assign env_tick   = strobe_r[0];
    assign seq_step   = step_r;
    assign duty       = duty_r;
    assign lenLoad    = len_load_r;
    assign lenEnable  = len_en_r;
    assign freq       = freq_r;
    assign trigger    = trig_r;

endmodule

// File: tb/tb_chan_ctrl.sv
// Bench for chan_ctrl: register-write vector table, long randomized runs against a
// cycle-count reference model, enable drop at step 3, and async reset mid-trigger.
module tb_chan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        apu_on;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        len_tick, sweep_tick, env_tick, trigger, lenEnable;
    logic [5:0]  lenLoad;
    logic [1:0]  duty;
    logic [10:0] freq;
    logic [2:0]  seq_step;

    chan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .apu_on(apu_on), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .len_tick(len_tick),
        .sweep_tick(sweep_tick), .env_tick(env_tick), .lenLoad(lenLoad),
        .trigger(trigger), .lenEnable(lenEnable), .duty(duty), .freq(freq),
        .seq_step(seq_step)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: enabled-cycle count plus architectural register contents.
    int         m_cnt;
    logic [1:0] m_duty;
    logic [5:0] m_ll;
    logic       m_le;
    logic [10:0] m_fr;
    logic       m_tr;

    wire [26:0] dut_vec = {len_tick, sweep_tick, env_tick, lenLoad, trigger,
                           lenEnable, duty, freq, seq_step};

    typedef struct {
        logic       a;
        logic       we;
        logic [2:0] ad;
        logic [7:0] d;
        logic [1:0] duty;
        logic [5:0] ll;
        logic       le;
        logic [10:0] fr;
        logic       tr;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [2:0] lse;
    } mark_t;

    vec_t  tbl[12];
    mark_t marks[8];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_duty = 2'd0; m_ll = 6'd0; m_le = 1'b0; m_fr = 11'd0; m_tr = 1'b0;
    endtask

    task automatic model_edge(input logic a, input logic we, input logic [2:0] ad,
                              input logic [7:0] d);
        if (!a) begin
            model_reset();
        end else begin
            m_cnt++;
            m_tr = we && (ad == 3'd4) && d[7];
            if (we && ad == 3'd1) begin m_duty = d[7:6]; m_ll = d[5:0]; end
            if (we && ad == 3'd3) m_fr[7:0] = d;
            if (we && ad == 3'd4) begin m_fr[10:8] = d[2:0]; m_le = d[6]; end
        end
    endtask

    // Every 8192 enabled cycles one step has been executed; step n is the (n+1)th.
    function automatic logic [26:0] exp_vec();
        logic l, s, e;
        int   x;
        l = 1'b0; s = 1'b0; e = 1'b0;
        if (m_cnt > 0 && m_cnt % 8192 == 0) begin
            x = ((m_cnt / 8192) - 1) % 8;
            l = (x % 2 == 0);
            s = (x == 2 || x == 6);
            e = (x == 7);
        end
        return {l, s, e, m_ll, m_tr, m_le, m_duty, m_fr, 3'((m_cnt / 8192) % 8)};
    endfunction

    task automatic cyc(input logic a, input logic we, input logic [2:0] ad, input logic [7:0] d);
        apu_on = a; wr_en = we; wr_addr = ad; wr_data = d;
        @(posedge clk);
        model_edge(a, we, ad, d);
        @(negedge clk);
        check("model", 64'(dut_vec), 64'(exp_vec()));
    endtask

    task automatic run_seg(input int n_cyc);
        logic       we;
        logic [2:0] ad;
        logic [7:0] d;
        for (int i = 0; i < n_cyc; i++) begin
            we = ($urandom_range(0, 3) == 0);
            ad = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            if (m_cnt + 1 == 8192) begin
                we = 1'b1; ad = 3'd4; d = d | 8'h80;
            end
            cyc(1'b1, we, ad, d);
            if (m_cnt == 8192)
                check("trig_with_len", 64'({trigger, len_tick}), 64'(2'b11));
            for (int k = 0; k < 8; k++)
                if (marks[k].cyc == m_cnt)
                    check($sformatf("strobes_c%0d", m_cnt),
                          64'({len_tick, sweep_tick, env_tick}), 64'(marks[k].lse));
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 3'd1, 8'hC5, 2'd3, 6'd5,  1'b0, 11'h000, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 3'd4, 8'hC3, 2'd3, 6'd5,  1'b1, 11'h300, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 3'd0, 8'h00, 2'd3, 6'd5,  1'b1, 11'h300, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 3'd4, 8'h40, 2'd3, 6'd5,  1'b1, 11'h000, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 3'd3, 8'hAB, 2'd3, 6'd5,  1'b1, 11'h0AB, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 3'd4, 8'h87, 2'd3, 6'd5,  1'b0, 11'h7AB, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 3'd4, 8'h85, 2'd3, 6'd5,  1'b0, 11'h5AB, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 3'd2, 8'hFF, 2'd3, 6'd5,  1'b0, 11'h5AB, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 3'd0, 8'hFF, 2'd3, 6'd5,  1'b0, 11'h5AB, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 3'd1, 8'h3F, 2'd0, 6'd63, 1'b0, 11'h5AB, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 3'd1, 8'hC5, 2'd0, 6'd0,  1'b0, 11'h000, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 8'h00, 2'd0, 6'd0,  1'b0, 11'h000, 1'b0};

        marks[0] = '{8191,  3'b000};
        marks[1] = '{8192,  3'b100};
        marks[2] = '{16384, 3'b000};
        marks[3] = '{24576, 3'b110};
        marks[4] = '{40960, 3'b100};
        marks[5] = '{57344, 3'b110};
        marks[6] = '{65535, 3'b000};
        marks[7] = '{65536, 3'b001};

        rst_n = 1'b0; apu_on = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'd0;
        model_reset();
        #2 check("reset_state", 64'(dut_vec), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].a, tbl[i].we, tbl[i].ad, tbl[i].d);
            check($sformatf("table_row%0d", i),
                  64'({duty, lenLoad, lenEnable, freq, trigger}),
                  64'({tbl[i].duty, tbl[i].ll, tbl[i].le, tbl[i].fr, tbl[i].tr}));
        end

        // Asynchronous reset in the middle of a trigger pulse.
        cyc(1'b1, 1'b1, 3'd4, 8'hC7);
        #1 rst_n = 1'b0;
        #1 check("async_reset_mid_trigger", 64'(dut_vec), 64'd0);
        model_reset();
        #1 rst_n = 1'b1;

        // Run into step 3 until the divider reads 5000, then drop the enable.
        run_seg(24576 + 5000);
        check("step3_before_drop", 64'(seq_step), 64'(3'd3));
        for (int i = 0; i < 100; i++)
            cyc(1'b0, 1'b1, (i % 2 == 0) ? 3'd4 : 3'd1, 8'hFF);
        check("off_all_zero", 64'(dut_vec), 64'd0);

        run_seg(65536);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
